// File: rtl/calc_pkg.sv
// Shared opcode, datapath-select and dispatcher state definitions for the calculator.
package calc_pkg;

    // Opcodes are button indices.
    localparam int unsigned OP_ADD = 0;
    localparam int unsigned OP_SUB = 1;
    localparam int unsigned OP_MUL = 2;
    localparam int unsigned OP_SQR = 3;

    // Legacy two-bit datapath select codes.
    localparam logic [1:0] SEL_UADD = 2'b00;
    localparam logic [1:0] SEL_SADD = 2'b01;
    localparam logic [1:0] SEL_MUL  = 2'b10;
    localparam logic [1:0] SEL_SQR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } disp_state_t;

    // Map an opcode and the signed mode captured with it onto the datapath select.
    // Opcodes past SQR are extension ops and ride on the multiplier path.
    function automatic logic [1:0] decode_sel(input logic [31:0] op, input logic sgd_l);
        logic [1:0] s;
        case (op)
            OP_ADD, OP_SUB: s = sgd_l ? SEL_SADD : SEL_UADD;
            OP_SQR:         s = SEL_SQR;
            default:        s = SEL_MUL;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Per-bit rising-edge detector for already-debounced button levels.
module edge_detect #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] lvl,
    output logic [N-1:0] rise
);

    logic [N-1:0] lvl_q;

    // History register; reset also loads the live level so a button held
    // through reset is seen as already pressed and never fires.
    always_ff @(posedge clk) begin
        lvl_q <= lvl;
    end

    // A rise is a level that is high now and was low last cycle; nothing fires during reset.
    always_comb begin
        rise = rst ? '0 : (lvl & ~lvl_q);
    end

endmodule

// File: rtl/op_dispatch.sv
// Button-press to single-operation dispatcher with one pending slot, start/done
// handshake to the arithmetic unit, result capture and done timeout.
module op_dispatch
    import calc_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_OPS = 4,
    parameter int TIMEOUT = 64,
    localparam int OP_W   = $clog2(NUM_OPS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               toggle_sgd,
    input  logic [NUM_OPS-1:0] op_btn,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    input  logic               done,
    input  logic [2*WIDTH-1:0] result_in,
    output logic               start,
    output logic [OP_W-1:0]    op_code,
    output logic [1:0]         sel,
    output logic               add_sub,
    output logic               sgd,
    output logic [WIDTH-1:0]   operand_a,
    output logic [WIDTH-1:0]   operand_b,
    output logic               busy,
    output logic [2*WIDTH-1:0] result_out,
    output logic               result_vld,
    output logic               dropped,
    output logic               err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sgd;
    } req_t;

    disp_state_t        state, state_nx;
    logic [NUM_OPS-1:0] op_press;
    logic               sgd_press;
    logic [OP_W-1:0]    win_idx;
    logic               any_op, multi;
    req_t               new_req, pend, issue_req;
    logic               pend_vld;
    logic               issue_en, drain, to_fire, drop_full;
    logic [CNT_W-1:0]   cnt;

    edge_detect #(.N(NUM_OPS + 1)) u_edge (
        .clk  (clk),
        .rst  (rst),
        .lvl  ({toggle_sgd, op_btn}),
        .rise ({sgd_press, op_press})
    );

    // Lowest-index press wins; any second simultaneous press is discarded.
    always_comb begin
        win_idx = '0;
        for (int i = NUM_OPS - 1; i >= 0; i--) begin
            if (op_press[i]) win_idx = OP_W'(i);
        end
        any_op  = |op_press;
        multi   = |(op_press & (op_press - NUM_OPS'(1)));
        // sgd register value at the press edge, before any same-edge toggle.
        new_req = '{op: win_idx, a: a_in, b: b_in, sgd: sgd};
    end

    // Issue and slot bookkeeping. IDLE with a full slot only happens when a press
    // landed in DONE with the slot empty; that request is issued from IDLE.
    always_comb begin
        to_fire   = (TIMEOUT != 0) && (state == WAIT) && !done && (cnt == TO_LAST);
        drain     = pend_vld && ((state == DONE) || (state == IDLE));
        issue_en  = drain || ((state == IDLE) && any_op);
        issue_req = pend_vld ? pend : new_req;
        drop_full = any_op && (to_fire || (pend_vld && !drain));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (issue_en) state_nx = ISSUE;
            ISSUE: state_nx = WAIT;
            WAIT: begin
                if (done)         state_nx = DONE;
                else if (to_fire) state_nx = IDLE;
            end
            DONE:  state_nx = pend_vld ? ISSUE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State-decoded handshake outputs.
    always_comb begin
        start      = (state == ISSUE);
        busy       = (state == ISSUE) || (state == WAIT);
        result_vld = (state == DONE);
    end

    // Issued-op registers and decode; these move only when an issue is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_code   <= '0;
            sel       <= '0;
            add_sub   <= 1'b0;
            operand_a <= '0;
            operand_b <= '0;
        end else if (issue_en) begin
            op_code   <= issue_req.op;
            sel       <= decode_sel(32'(issue_req.op), issue_req.sgd);
            add_sub   <= (issue_req.op == OP_W'(OP_SUB));
            operand_a <= issue_req.a;
            operand_b <= (issue_req.op == OP_W'(OP_SQR)) ? issue_req.a : issue_req.b;
        end
    end

    // Pending slot: filled by a press while busy, refilled in the cycle it drains,
    // flushed on timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= '0;
            pend_vld <= 1'b0;
        end else if (to_fire) begin
            pend_vld <= 1'b0;
        end else if (drain) begin
            pend     <= new_req;
            pend_vld <= any_op;
        end else if ((state != IDLE) && any_op && !pend_vld) begin
            pend     <= new_req;
            pend_vld <= 1'b1;
        end
    end

    // Done watchdog: cleared while issuing, counts WAIT cycles.
    always_ff @(posedge clk) begin
        if (rst)                 cnt <= '0;
        else if (state == ISSUE) cnt <= '0;
        else if (state == WAIT)  cnt <= cnt + CNT_W'(1);
    end

    // Mode toggle, result capture, drop pulse and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            sgd        <= 1'b0;
            result_out <= '0;
            dropped    <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (sgd_press) sgd <= ~sgd;
            if ((state == WAIT) && done) result_out <= result_in;
            dropped <= multi || drop_full;
            if (to_fire)       err <= 1'b1;
            else if (issue_en) err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_op_dispatch.sv
// Self-checking bench for op_dispatch: vector table plus hand-written corner sequences,
// with a result scoreboard fed at issue time and drained on result_vld.
module tb_op_dispatch;
    import calc_pkg::*;

    localparam int WIDTH   = 8;
    localparam int NUM_OPS = 4;
    localparam int TIMEOUT = 8;
    localparam int OP_W    = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               toggle_sgd = 1'b0;
    logic [NUM_OPS-1:0] op_btn = '0;
    logic [WIDTH-1:0]   a_in = '0;
    logic [WIDTH-1:0]   b_in = '0;
    logic               done = 1'b0;
    logic [2*WIDTH-1:0] result_in = '0;
    logic               start, add_sub, sgd, busy, result_vld, dropped, err;
    logic [OP_W-1:0]    op_code;
    logic [1:0]         sel;
    logic [WIDTH-1:0]   operand_a, operand_b;
    logic [2*WIDTH-1:0] result_out;

    op_dispatch #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .toggle_sgd (toggle_sgd),
        .op_btn     (op_btn),
        .a_in       (a_in),
        .b_in       (b_in),
        .done       (done),
        .result_in  (result_in),
        .start      (start),
        .op_code    (op_code),
        .sel        (sel),
        .add_sub    (add_sub),
        .sgd        (sgd),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .busy       (busy),
        .result_out (result_out),
        .result_vld (result_vld),
        .dropped    (dropped),
        .err        (err)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] sbq[$];

    typedef struct {
        bit          tog;
        int          op;
        logic [7:0]  a;
        logic [7:0]  b;
        int          lat;
        logic        exp_sgd;
        logic [1:0]  exp_sel;
        logic        exp_as;
        logic [7:0]  exp_opb;
    } vec_t;

    vec_t vt[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic unit: operands zero/sign-extended to 16 bits.
    function automatic logic [15:0] model(input int op, input logic [7:0] a,
                                          input logic [7:0] b, input logic s);
        logic [15:0] ea, eb;
        ea = s ? {{8{a[7]}}, a} : {8'h00, a};
        eb = s ? {{8{b[7]}}, b} : {8'h00, b};
        case (op)
            0:       return ea + eb;
            1:       return ea - eb;
            2:       return ea * eb;
            default: return ea * ea;
        endcase
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_start"},      32'(start), 0);
        chk({tag, "_op_code"},    32'(op_code), 0);
        chk({tag, "_sel"},        32'(sel), 0);
        chk({tag, "_add_sub"},    32'(add_sub), 0);
        chk({tag, "_sgd"},        32'(sgd), 0);
        chk({tag, "_operand_a"},  32'(operand_a), 0);
        chk({tag, "_operand_b"},  32'(operand_b), 0);
        chk({tag, "_busy"},       32'(busy), 0);
        chk({tag, "_result_out"}, 32'(result_out), 0);
        chk({tag, "_result_vld"}, 32'(result_vld), 0);
        chk({tag, "_dropped"},    32'(dropped), 0);
        chk({tag, "_err"},        32'(err), 0);
    endtask

    // Press one op button for a single edge; returns in the ISSUE cycle.
    task automatic press(input int op, input logic [7:0] a, input logic [7:0] b);
        a_in = a;
        b_in = b;
        op_btn[op] = 1'b1;
        tick();
        op_btn = '0;
    endtask

    // Called in the first WAIT cycle: done arrives in WAIT cycle 'lat'.
    task automatic finish_op(input int lat, input logic [15:0] res);
        repeat (lat - 1) tick();
        chk("busy_before_done", 32'(busy), 1);
        done = 1'b1;
        result_in = res;
        tick();
        done = 1'b0;
        result_in = 16'hDEAD;
        chk("busy_in_done", 32'(busy), 0);
        tick();
        chk("result_held", 32'(result_out), 32'(res));
        chk("result_vld_pulse", 32'(result_vld), 0);
    endtask

    // Scoreboard drain: every result_vld must match the oldest outstanding result.
    initial begin
        logic [15:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (result_vld === 1'b1) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_result_vld: got result_out 0x%0h, want no result (t=%0t)",
                             result_out, $time);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_result", 32'(result_out), 32'(e));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at t=%0t, want finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1'b0, 2, 8'd12,  8'd10,  3, 1'b0, 2'b10, 1'b0, 8'd10};
        vt[1] = '{1'b1, 1, 8'h05,  8'h07,  2, 1'b1, 2'b01, 1'b1, 8'h07};
        vt[2] = '{1'b0, 3, 8'd9,   8'd3,   1, 1'b1, 2'b11, 1'b0, 8'd9};
        vt[3] = '{1'b0, 0, 8'd200, 8'd100, 2, 1'b1, 2'b01, 1'b0, 8'd100};
        vt[4] = '{1'b1, 0, 8'd200, 8'd100, 4, 1'b0, 2'b00, 1'b0, 8'd100};
        vt[5] = '{1'b0, 1, 8'd3,   8'd250, 1, 1'b0, 2'b00, 1'b1, 8'd250};

        // Reset with SUB held: nothing may fire once reset releases.
        op_btn = 4'b0010;
        tick();
        tick();
        rst = 1'b0;
        chk_all_zero("reset");
        tick();
        tick();
        chk("held_thru_reset_start", 32'(start), 0);
        chk("held_thru_reset_busy", 32'(busy), 0);
        op_btn = '0;
        tick();

        // Table-driven single operations.
        for (int i = 0; i < 6; i++) begin
            if (vt[i].tog) begin
                toggle_sgd = 1'b1;
                tick();
                toggle_sgd = 1'b0;
                tick();
            end
            press(vt[i].op, vt[i].a, vt[i].b);
            chk("v_start",     32'(start), 1);
            chk("v_op_code",   32'(op_code), 32'(vt[i].op));
            chk("v_sel",       32'(sel), 32'(vt[i].exp_sel));
            chk("v_add_sub",   32'(add_sub), 32'(vt[i].exp_as));
            chk("v_operand_a", 32'(operand_a), 32'(vt[i].a));
            chk("v_operand_b", 32'(operand_b), 32'(vt[i].exp_opb));
            chk("v_sgd",       32'(sgd), 32'(vt[i].exp_sgd));
            sbq.push_back(model(vt[i].op, vt[i].a, vt[i].b, vt[i].exp_sgd));
            tick();
            chk("v_start_pulse", 32'(start), 0);
            finish_op(vt[i].lat, model(vt[i].op, vt[i].a, vt[i].b, vt[i].exp_sgd));
        end

        // ADD and MUL on the same edge: ADD wins, one drop pulse.
        a_in = 8'd7;
        b_in = 8'd8;
        op_btn = 4'b0101;
        tick();
        op_btn = '0;
        chk("simul_start", 32'(start), 1);
        chk("simul_op_code", 32'(op_code), 0);
        chk("simul_dropped", 32'(dropped), 1);
        sbq.push_back(16'd15);
        tick();
        chk("simul_dropped_once", 32'(dropped), 0);
        finish_op(2, 16'd15);

        // Pending slot: MUL pended during WAIT, SQR dropped, MUL issued right after DONE.
        press(0, 8'd1, 8'd2);
        sbq.push_back(16'd3);
        tick();
        a_in = 8'd4;
        b_in = 8'd5;
        op_btn[2] = 1'b1;
        sbq.push_back(16'd20);
        tick();
        op_btn = '0;
        chk("pend_fill_no_drop", 32'(dropped), 0);
        a_in = 8'd99;
        op_btn[3] = 1'b1;
        tick();
        op_btn = '0;
        chk("pend_full_dropped", 32'(dropped), 1);
        done = 1'b1;
        result_in = 16'd3;
        tick();
        done = 1'b0;
        result_in = 16'hDEAD;
        chk("pend_done_start", 32'(start), 0);
        chk("pend_done_dropped", 32'(dropped), 0);
        tick();
        chk("pend_issue_start", 32'(start), 1);
        chk("pend_issue_op", 32'(op_code), 2);
        chk("pend_issue_sel", 32'(sel), 32'(SEL_MUL));
        chk("pend_issue_a", 32'(operand_a), 4);
        chk("pend_issue_b", 32'(operand_b), 5);
        tick();
        finish_op(2, 16'd20);

        // Timeout: done never comes; 8 WAIT cycles, then IDLE with err and the slot flushed.
        press(2, 8'd2, 8'd3);
        chk("to_start", 32'(start), 1);
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk("to_busy", 32'(busy), 1);
            chk("to_err_low", 32'(err), 0);
            op_btn = (c == 1) ? 4'b0001 : 4'b0000;
        end
        tick();
        chk("to_idle", 32'(busy), 0);
        chk("to_err_set", 32'(err), 1);
        repeat (3) begin
            tick();
            chk("to_pend_flushed", 32'(start), 0);
        end
        chk("to_err_sticky", 32'(err), 1);

        // Next issue clears err; then a reset in WAIT drops everything.
        press(0, 8'd1, 8'd1);
        chk("err_clear_start", 32'(start), 1);
        chk("err_clear", 32'(err), 0);
        toggle_sgd = 1'b1;
        tick();
        toggle_sgd = 1'b0;
        chk("rst_pre_sgd", 32'(sgd), 1);
        op_btn[1] = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("rst_wait");
        repeat (3) begin
            tick();
            chk("rst_no_start", 32'(start), 0);
        end
        op_btn = '0;
        tick();

        chk("sb_empty", 32'(sbq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
